// File: rtl/lt24_rect_scheduler.sv
// lt24_rect_scheduler
// Arbitrated solid-colour rectangle filler for the LT24 display pixel port.
// Grants one requester at a time, clips its rectangle to the panel and
// streams the pixels row-major over the xAddr/yAddr/pixelData handshake.
//
// Ports:
//   clock, reset         system clock, async active-high reset (resetApp)
//   req                  per-requester fill request (level, sampled in IDLE)
//   reqX/reqY/reqW/reqH  packed per-requester rectangle geometry
//   reqColour            packed per-requester RGB565 colour
//   grant, done          one-cycle one-hot pulses
//   busy                 high whenever not IDLE
//   xAddr/yAddr/pixelData/pixelWrite  to display; pixelReady from display
//
// Build option: define LT24_SCHED_FIXED_PRIO_EN for fixed priority (lowest
// index wins); otherwise round-robin arbitration is used.
module lt24_rect_scheduler #(
   parameter int unsigned WIDTH   = 240,
   parameter int unsigned HEIGHT  = 320,
   parameter int unsigned NUM_REQ = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [8*NUM_REQ-1:0]  reqX,
   input  logic [9*NUM_REQ-1:0]  reqY,
   input  logic [8*NUM_REQ-1:0]  reqW,
   input  logic [9*NUM_REQ-1:0]  reqH,
   input  logic [16*NUM_REQ-1:0] reqColour,
   output logic [NUM_REQ-1:0]    grant,
   output logic [NUM_REQ-1:0]    done,
   output logic                  busy,
   output logic [7:0]            xAddr,
   output logic [8:0]            yAddr,
   output logic [15:0]           pixelData,
   output logic                  pixelWrite,
   input  logic                  pixelReady
);

   localparam int unsigned XW    = 8;
   localparam int unsigned YW    = 9;
   localparam int unsigned CW    = 16;
   localparam int unsigned AW    = 10;
   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, LATCH, DRAW, DONE} state_t;

   state_t             state;
   logic [IDX_W-1:0]   owner;
   logic [XW-1:0]      x0_r;
   logic [YW-1:0]      y0_r;
   logic [XW-1:0]      w_r;
   logic [YW-1:0]      h_r;
   logic [CW-1:0]      colour_r;
   logic [XW-1:0]      x_last;
   logic [YW-1:0]      y_last;

   logic [IDX_W-1:0]   win_idx;
   logic               win_found;

`ifdef LT24_SCHED_FIXED_PRIO_EN
   // Fixed priority: scan downwards so the lowest requesting index is kept.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_idx   = IDX_W'(i);
            win_found = 1'b1;
         end
      end
   end
`else
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   cand;

   // Round-robin: search starts one past the last granted index.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      cand      = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
         if (!win_found && req[cand]) begin
            win_idx   = cand;
            win_found = 1'b1;
         end
      end
   end
`endif

   // Field mux for the winning requester.
   logic [XW-1:0] sel_x;
   logic [YW-1:0] sel_y;
   logic [XW-1:0] sel_w;
   logic [YW-1:0] sel_h;
   logic [CW-1:0] sel_c;

   always_comb begin
      sel_x = '0;
      sel_y = '0;
      sel_w = '0;
      sel_h = '0;
      sel_c = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (IDX_W'(i) == win_idx) begin
            sel_x = reqX[XW*i +: XW];
            sel_y = reqY[YW*i +: YW];
            sel_w = reqW[XW*i +: XW];
            sel_h = reqH[YW*i +: YW];
            sel_c = reqColour[CW*i +: CW];
         end
      end
   end

   // Emptiness test and clipped end coordinates, widened so nothing wraps.
   logic [AW-1:0] x0_w, y0_w, w_w, h_w, x_room, y_room, w_eff, h_eff;
   logic          empty_c;
   logic [XW-1:0] x_last_c;
   logic [YW-1:0] y_last_c;

   always_comb begin
      x0_w     = AW'(x0_r);
      y0_w     = AW'(y0_r);
      w_w      = AW'(w_r);
      h_w      = AW'(h_r);
      empty_c  = (x0_w >= AW'(WIDTH)) || (y0_w >= AW'(HEIGHT)) ||
                 (w_r == '0) || (h_r == '0);
      x_room   = AW'(WIDTH) - x0_w;
      y_room   = AW'(HEIGHT) - y0_w;
      w_eff    = (w_w < x_room) ? w_w : x_room;
      h_eff    = (h_w < y_room) ? h_w : y_room;
      x_last_c = XW'(x0_w + w_eff - AW'(1));
      y_last_c = YW'(y0_w + h_eff - AW'(1));
   end

   // Scheduler FSM with registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= '0;
         x0_r       <= '0;
         y0_r       <= '0;
         w_r        <= '0;
         h_r        <= '0;
         colour_r   <= '0;
         x_last     <= '0;
         y_last     <= '0;
         grant      <= '0;
         done       <= '0;
         busy       <= 1'b0;
         xAddr      <= '0;
         yAddr      <= '0;
         pixelData  <= '0;
         pixelWrite <= 1'b0;
`ifndef LT24_SCHED_FIXED_PRIO_EN
         rr_ptr     <= IDX_W'(NUM_REQ - 1);
`endif
      end else begin
         grant <= '0;
         done  <= '0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  grant    <= NUM_REQ'(1) << win_idx;
                  owner    <= win_idx;
                  x0_r     <= sel_x;
                  y0_r     <= sel_y;
                  w_r      <= sel_w;
                  h_r      <= sel_h;
                  colour_r <= sel_c;
                  busy     <= 1'b1;
                  state    <= LATCH;
`ifndef LT24_SCHED_FIXED_PRIO_EN
                  rr_ptr   <= win_idx;
`endif
               end
            end
            LATCH: begin
               if (empty_c) begin
                  done  <= NUM_REQ'(1) << owner;
                  state <= DONE;
               end else begin
                  xAddr      <= x0_r;
                  yAddr      <= y0_r;
                  pixelData  <= colour_r;
                  pixelWrite <= 1'b1;
                  x_last     <= x_last_c;
                  y_last     <= y_last_c;
                  state      <= DRAW;
               end
            end
            DRAW: begin
               if (pixelReady) begin
                  if (xAddr == x_last) begin
                     if (yAddr == y_last) begin
                        pixelWrite <= 1'b0;
                        done       <= NUM_REQ'(1) << owner;
                        state      <= DONE;
                     end else begin
                        xAddr <= x0_r;
                        yAddr <= yAddr + YW'(1);
                     end
                  end else begin
                     xAddr <= xAddr + XW'(1);
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lt24_rect_scheduler.sv
// Self-checking bench for lt24_rect_scheduler: expected pixels are queued
// when a request is driven and popped as the display handshake accepts them.
module tb_lt24_rect_scheduler;

   localparam int N = 4;
   localparam int W = 240;
   localparam int H = 320;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  req = '0;
   logic [8*N-1:0]  reqX = '0;
   logic [9*N-1:0]  reqY = '0;
   logic [8*N-1:0]  reqW = '0;
   logic [9*N-1:0]  reqH = '0;
   logic [16*N-1:0] reqColour = '0;
   logic [N-1:0]  grant, done;
   logic          busy;
   logic [7:0]    xAddr;
   logic [8:0]    yAddr;
   logic [15:0]   pixelData;
   logic          pixelWrite;
   logic          pixelReady = 1'b1;

   typedef struct {
      logic [7:0]  x;
      logic [8:0]  y;
      logic [15:0] c;
   } pix_t;

   pix_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   xfer_count = 0;
   bit   mon_en = 1'b1;

   lt24_rect_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_REQ(N)) dut (
      .clock(clock), .reset(reset), .req(req),
      .reqX(reqX), .reqY(reqY), .reqW(reqW), .reqH(reqH), .reqColour(reqColour),
      .grant(grant), .done(done), .busy(busy),
      .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
      .pixelWrite(pixelWrite), .pixelReady(pixelReady)
   );

   always #5 clock = ~clock;

   // Pixel monitor: a transfer happens at the next rising edge.
   always @(negedge clock) begin
      pix_t e;
      if (mon_en && !reset && pixelWrite === 1'b1 && pixelReady === 1'b1) begin
         checks++;
         xfer_count++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL pixel_unexpected: got (%0d,%0d,%h), required no write",
                     xAddr, yAddr, pixelData);
         end else begin
            e = sb.pop_front();
            if ({xAddr, yAddr, pixelData} !== {e.x, e.y, e.c}) begin
               errors++;
               $display("FAIL pixel: got (%0d,%0d,%h), required (%0d,%0d,%h)",
                        xAddr, yAddr, pixelData, e.x, e.y, e.c);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int i, input int x, input int y, input int w,
                          input int h, input int c);
      reqX[8*i +: 8]       = 8'(x);
      reqY[9*i +: 9]       = 9'(y);
      reqW[8*i +: 8]       = 8'(w);
      reqH[9*i +: 9]       = 9'(h);
      reqColour[16*i +: 16] = 16'(c);
   endtask

   // Reference clipping model: enumerate on-panel pixels row-major.
   task automatic push_rect(input int x, input int y, input int w, input int h,
                            input int c);
      pix_t p;
      for (int yy = y; yy < y + h && yy < H; yy++) begin
         for (int xx = x; xx < x + w && xx < W; xx++) begin
            p.x = 8'(xx);
            p.y = 9'(yy);
            p.c = 16'(c);
            sb.push_back(p);
         end
      end
   endtask

   // Wait (bounded) for a done pulse; returns cycles waited and the pulse.
   task automatic wait_done(output int cyc, output logic [N-1:0] d);
      cyc = 0;
      d   = '0;
      while (cyc < 100) begin
         tick();
         cyc++;
         if (done !== '0) begin
            d = done;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({grant, done} !== '0) begin
         errors++;
         $display("FAIL reset_pulses: got grant=%b done=%b, required 0", grant, done);
      end
      checks++;
      if ({busy, pixelWrite} !== 2'b00) begin
         errors++;
         $display("FAIL reset_flags: got busy=%b pw=%b, required 0", busy, pixelWrite);
      end
      checks++;
      if ({xAddr, yAddr, pixelData} !== '0) begin
         errors++;
         $display("FAIL reset_bus: got (%0d,%0d,%h), required 0", xAddr, yAddr, pixelData);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single();
      int cyc, xf0;
      logic [N-1:0] d;
      xf0 = xfer_count;
      push_rect(10, 20, 3, 2, 16'h001F);
      set_req(0, 10, 20, 3, 2, 16'h001F);
      req = 4'b0001;
      tick();
      checks++;
      if ({grant, busy} !== {4'b0001, 1'b1}) begin
         errors++;
         $display("FAIL single_grant: got grant=%b busy=%b, required 0001/1", grant, busy);
      end
      req = '0;
      wait_done(cyc, d);
      checks++;
      if (d !== 4'b0001 || cyc != 7) begin
         errors++;
         $display("FAIL single_done: got done=%b after %0d, required 0001 after 7", d, cyc);
      end
      checks++;
      if (xfer_count - xf0 != 6 || sb.size() != 0 || pixelWrite !== 1'b0) begin
         errors++;
         $display("FAIL single_count: got %0d xfers left=%0d pw=%b, required 6/0/0",
                  xfer_count - xf0, sb.size(), pixelWrite);
      end
      tick();
      checks++;
      if ({busy, done, grant} !== '0) begin
         errors++;
         $display("FAIL single_idle: got busy=%b done=%b grant=%b, required 0", busy, done, grant);
      end
   endtask

   task automatic test_clip();
      int cyc, xf0;
      logic [N-1:0] d;
      xf0 = xfer_count;
      push_rect(238, 318, 5, 5, 16'hF800);
      set_req(2, 238, 318, 5, 5, 16'hF800);
      req = 4'b0100;
      tick();
      checks++;
      if (grant !== 4'b0100) begin
         errors++;
         $display("FAIL clip_grant: got %b, required 0100", grant);
      end
      req = '0;
      wait_done(cyc, d);
      checks++;
      if (d !== 4'b0100 || cyc != 5 || xfer_count - xf0 != 4 || sb.size() != 0) begin
         errors++;
         $display("FAIL clip_done: got done=%b cyc=%0d xfers=%0d, required 0100/5/4",
                  d, cyc, xfer_count - xf0);
      end
      tick();
      xf0 = xfer_count;
      set_req(1, 240, 10, 4, 4, 16'h1234);
      req = 4'b0010;
      tick();
      checks++;
      if (grant !== 4'b0010) begin
         errors++;
         $display("FAIL empty_grant: got %b, required 0010", grant);
      end
      req = '0;
      wait_done(cyc, d);
      checks++;
      if (d !== 4'b0010 || cyc != 1 || xfer_count != xf0 || pixelWrite !== 1'b0) begin
         errors++;
         $display("FAIL empty_done: got done=%b cyc=%0d xfers=%0d, required 0010/1/0",
                  d, cyc, xfer_count - xf0);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int xf0;
      bit found, prev_pw, prev_ready;
      logic [16:0] prev_addr;
      xf0 = xfer_count;
      found = 1'b0;
      push_rect(100, 100, 2, 2, 16'h07E0);
      set_req(3, 100, 100, 2, 2, 16'h07E0);
      req = 4'b1000;
      tick();
      checks++;
      if (grant !== 4'b1000) begin
         errors++;
         $display("FAIL bp_grant: got %b, required 1000", grant);
      end
      req = '0;
      pixelReady = 1'b0;
      prev_ready = 1'b0;
      prev_pw = pixelWrite;
      prev_addr = {xAddr, yAddr};
      for (int k = 0; k < 40; k++) begin
         tick();
         if (pixelWrite && prev_pw && !prev_ready) begin
            checks++;
            if ({xAddr, yAddr} !== prev_addr) begin
               errors++;
               $display("FAIL bp_hold: got (%0d,%0d), required (%0d,%0d)",
                        xAddr, yAddr, prev_addr[16:9], prev_addr[8:0]);
            end
         end
         if (done !== '0) begin
            found = 1'b1;
            checks++;
            if (done !== 4'b1000 || xfer_count - xf0 != 4 || !prev_ready || sb.size() != 0) begin
               errors++;
               $display("FAIL bp_done: got done=%b xfers=%0d last_ready=%b, required 1000/4/1",
                        done, xfer_count - xf0, prev_ready);
            end
            break;
         end
         prev_pw = pixelWrite;
         prev_addr = {xAddr, yAddr};
         pixelReady = ~pixelReady;
         prev_ready = pixelReady;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL bp_timeout: got no done, required done=1000");
      end
      pixelReady = 1'b1;
      tick();
   endtask

   task automatic test_arbitration();
      int ord[6];
      int ng, nd, re0_left;
      bit pending;
`ifdef LT24_SCHED_FIXED_PRIO_EN
      ord = '{0, 0, 0, 1, 2, 3};
`else
      ord = '{0, 1, 2, 3, 0, 0};
`endif
      for (int i = 0; i < N; i++) set_req(i, i * 10, 5, 2, 1, 16'h1000 * (i + 1));
      for (int k = 0; k < 6; k++) push_rect(ord[k] * 10, 5, 2, 1, 16'h1000 * (ord[k] + 1));
      ng = 0;
      nd = 0;
      re0_left = 2;
      pending = 1'b0;
      req = 4'b1111;
      for (int t = 0; t < 300 && nd < 6; t++) begin
         tick();
         if (pending) begin
            req[0] = 1'b1;
            pending = 1'b0;
         end
         if (grant !== '0) begin
            checks++;
            if (ng >= 6 || grant !== 4'(1 << ord[ng])) begin
               errors++;
               $display("FAIL arb_grant%0d: got %b, required %b", ng, grant,
                        (ng < 6) ? 4'(1 << ord[ng]) : 4'b0000);
            end
            ng++;
         end
         if (done !== '0) begin
            checks++;
            if (done !== 4'(1 << ord[nd])) begin
               errors++;
               $display("FAIL arb_done%0d: got %b, required %b", nd, done, 4'(1 << ord[nd]));
            end
            nd++;
            req = req & ~done;
            if (done[0] && re0_left > 0) begin
               re0_left--;
               pending = 1'b1;
            end
         end
      end
      checks++;
      if (nd != 6 || ng != 6 || sb.size() != 0) begin
         errors++;
         $display("FAIL arb_total: got grants=%0d dones=%0d left=%0d, required 6/6/0",
                  ng, nd, sb.size());
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid_draw();
      int xf0, cyc;
      bit seen_done;
      logic [N-1:0] d;
      xf0 = xfer_count;
      push_rect(50, 60, 4, 4, 16'hABCD);
      set_req(2, 50, 60, 4, 4, 16'hABCD);
      req = 4'b0100;
      tick();
      req = '0;
      for (int k = 0; k < 20 && xfer_count - xf0 < 2; k++) tick();
      checks++;
      if ({pixelWrite, xAddr, yAddr} !== {1'b1, 8'd52, 9'd60}) begin
         errors++;
         $display("FAIL rst_third: got pw=%b (%0d,%0d), required 1 (52,60)",
                  pixelWrite, xAddr, yAddr);
      end
      mon_en = 1'b0;
      reset = 1'b1;
      #1;
      checks++;
      if ({grant, done, busy, pixelWrite, xAddr, yAddr, pixelData} !== '0) begin
         errors++;
         $display("FAIL rst_async: got grant=%b done=%b busy=%b pw=%b (%0d,%0d,%h), required 0",
                  grant, done, busy, pixelWrite, xAddr, yAddr, pixelData);
      end
      sb.delete();
      seen_done = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (done !== '0 || busy !== 1'b0) seen_done = 1'b1;
      end
      checks++;
      if (seen_done) begin
         errors++;
         $display("FAIL rst_no_done: got done/busy after abort, required none");
      end
      mon_en = 1'b1;
      push_rect(0, 0, 1, 1, 16'h1234);
      push_rect(30, 40, 1, 1, 16'h4321);
      set_req(1, 0, 0, 1, 1, 16'h1234);
      set_req(3, 30, 40, 1, 1, 16'h4321);
      req = 4'b1010;
      tick();
      checks++;
      if (grant !== 4'b0010) begin
         errors++;
         $display("FAIL rst_first_grant: got %b, required 0010", grant);
      end
      req = 4'b1000;
      wait_done(cyc, d);
      checks++;
      if (d !== 4'b0010) begin
         errors++;
         $display("FAIL rst_done1: got %b, required 0010", d);
      end
      wait_done(cyc, d);
      req = '0;
      checks++;
      if (d !== 4'b1000 || sb.size() != 0) begin
         errors++;
         $display("FAIL rst_done3: got %b left=%0d, required 1000/0", d, sb.size());
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_clip();
      test_backpressure();
      test_arbitration();
      test_reset_mid_draw();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
